// File: rtl/fft8_bitrev_buffer.sv
// fft8_bitrev_buffer: collects one 2**N-sample frame in natural order and replays it in bit-reversed order.
module fft8_bitrev_buffer #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_idx,
    output logic          out_last
);
    typedef enum logic {FILL, DRAIN} state_t;
    localparam logic [N:0] LAST = {1'b0, {N{1'b1}}};

    state_t        r_state;
    logic [N:0]    r_wr_cnt;
    logic [N:0]    r_rd_cnt;
    logic [DW-1:0] r_mem [2**N];
    logic [N-1:0]  w_wr_addr;
    logic          w_in_xfer;
    logic          w_out_xfer;

    always_comb begin
        w_wr_addr = '0;
        for (int i = 0; i < N; i++) w_wr_addr[i] = r_wr_cnt[N-1-i];
    end

    // handshakes are gated by rst so nothing is offered while reset is held
    assign in_ready   = rst && r_state == FILL;
    assign out_valid  = rst && r_state == DRAIN;
    assign out_data   = out_valid ? r_mem[r_rd_cnt[N-1:0]] : '0;
    assign out_idx    = out_valid ? r_rd_cnt[N-1:0] : '0;
    assign out_last   = out_valid && r_rd_cnt == LAST;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= FILL;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (w_in_xfer) begin
            r_wr_cnt <= r_wr_cnt == LAST ? '0 : r_wr_cnt + 1'b1;
            if (r_wr_cnt == LAST) r_state <= DRAIN;
        end else if (w_out_xfer) begin
            r_rd_cnt <= r_rd_cnt == LAST ? '0 : r_rd_cnt + 1'b1;
            if (r_rd_cnt == LAST) r_state <= FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) r_mem[w_wr_addr] <= in_data;
    end
endmodule

// File: tb/tb_fft8_bitrev_buffer.sv
// tb_fft8_bitrev_buffer: directed frames with hand-computed bit-reversed output order.
module tb_fft8_bitrev_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_idx;
    logic       out_last;

    int n_vec = 0;
    int n_err = 0;
    int rev[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    fft8_bitrev_buffer #(.N(3), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int base, input int cnt, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                #1 chk("rdy_gap", in_ready, 1);
                cyc();
            end
            in_data  = 8'(base + i);
            in_valid = 1'b1;
            #1 chk("rdy_fill", in_ready, 1);
            chk("vld_fill", out_valid, 0);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int base, input int cnt, input int stall_k, input bit junk);
        for (int k = 0; k < cnt; k++) begin
            if (k == stall_k) begin
                for (int s = 0; s < 3; s++) begin
                    out_ready = 1'b0;
                    #1 chk("stall_vld", out_valid, 1);
                    chk("stall_data", out_data, 32'(base + rev[k]));
                    chk("stall_idx", out_idx, 32'(k));
                    cyc();
                end
            end
            out_ready = 1'b1;
            in_valid  = junk;
            in_data   = 8'd99;
            #1 chk("vld", out_valid, 1);
            chk("data", out_data, 32'(base + rev[k]));
            chk("idx", out_idx, 32'(k));
            chk("last", out_last, k == 7 ? 32'd1 : 32'd0);
            chk("rdy_drain", in_ready, 0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (cnt == 8) begin
            #1 chk("rdy_after", in_ready, 1);
            chk("vld_after", out_valid, 0);
        end
    endtask

    initial begin
        #1 chk("rst_rdy", in_ready, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_data", out_data, 0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        out_ready = 1'b1;
        #1 chk("fill_ordy", out_valid, 0);
        out_ready = 1'b0;

        send(10, 8, 1'b0);
        drain(10, 8, -1, 1'b0);

        send(10, 8, 1'b1);
        drain(10, 8, 2, 1'b0);

        send(10, 8, 1'b0);
        drain(10, 8, -1, 1'b1);
        send(20, 8, 1'b0);
        drain(20, 8, -1, 1'b0);

        send(10, 3, 1'b0);
        rst = 1'b0;
        #1 chk("mrst_rdy", in_ready, 0);
        chk("mrst_vld", out_valid, 0);
        in_valid = 1'b1;
        in_data  = 8'd77;
        cyc();
        in_valid = 1'b0;
        rst = 1'b1;
        send(30, 8, 1'b0);
        drain(30, 8, -1, 1'b0);

        send(40, 8, 1'b0);
        drain(40, 4, -1, 1'b0);
        #2 rst = 1'b0;
        #1 chk("drst_vld", out_valid, 0);
        chk("drst_rdy", in_ready, 0);
        chk("drst_idx", out_idx, 0);
        chk("drst_last", out_last, 0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("drst_rel_rdy", in_ready, 1);
        send(50, 8, 1'b0);
        drain(50, 8, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
